// File: rtl/lvt_mem_2wnr_pkg.sv
// Shared types and defaults for the two-write LVT memory: FSM state encoding,
// default geometry and a slicing macro for the packed per-port buses.
`ifndef LVT_MEM_2WNR_PKG_SV
`define LVT_MEM_2WNR_PKG_SV

`define LVT_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package lvt_mem_2wnr_pkg;

    typedef enum logic {
        LVT_INIT = 1'b0,
        LVT_RUN  = 1'b1
    } lvt_state_e;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_DEPTH    = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_READ = 4;

endpackage

`endif

// File: rtl/lvt_mem_2wnr_bank.sv
// Simple 1-write/1-read memory bank: synchronous write, registered read,
// no reset (contents are defined by the top-level init sweep).
module mem_bank_1w1r
    import lvt_mem_2wnr_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Read samples the pre-write contents, giving read-first behaviour.
    always_comb begin
        rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/lvt_mem_2wnr.sv
// Two-write, NUM_READ-read memory steered by a live value table, with an
// init sweep that zeroes storage after reset. Define LVT_MEM_BYPASS_EN for write-first reads.
module lvt_mem_2wnr
    import lvt_mem_2wnr_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_READ = DEF_NUM_READ
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       ready,
    input  logic                       we0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          write_addr0,
    input  logic [ADDR_W-1:0]          write_addr1,
    input  logic [WIDTH-1:0]           write_data0,
    input  logic [WIDTH-1:0]           write_data1,
    input  logic [NUM_READ*ADDR_W-1:0] read_addr,
    output logic [NUM_READ*WIDTH-1:0]  read_data
);

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

    lvt_state_e          state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;
    logic [DEPTH-1:0]    lvt_q, lvt_d;
    logic [NUM_READ-1:0] lvt_sel_q, lvt_sel_d;

    logic                init_active;
    logic                run_active;
    logic                wr_en0;
    logic                wr_en1;
    logic                bank0_we;
    logic [ADDR_W-1:0]   bank0_waddr;
    logic [WIDTH-1:0]    bank0_wdata;
    logic [WIDTH-1:0]    bank0_rdata [NUM_READ];
    logic [WIDTH-1:0]    bank1_rdata [NUM_READ];

    // Reset has priority over both the sweep and user writes on its edge.
    always_comb begin
        init_active = (state_q == LVT_INIT) && !reset;
        run_active  = (state_q == LVT_RUN) && !reset;
        wr_en0      = run_active && we0;
        wr_en1      = run_active && we1;
        bank0_we    = init_active || wr_en0;
        bank0_waddr = init_active ? count_q[ADDR_W-1:0] : write_addr0;
        bank0_wdata = init_active ? '0 : write_data0;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ready_d = ready_q;
        if (reset) begin
            state_d = LVT_INIT;
            count_d = '0;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                LVT_INIT: begin
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_ADDR) begin
                        state_d = LVT_RUN;
                        ready_d = 1'b1;
                    end
                end
                LVT_RUN: begin
                    ready_d = 1'b1;
                end
                default: begin
                    state_d = LVT_INIT;
                    count_d = '0;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    // Port 1 is applied last so it owns the LVT entry on a collision.
    always_comb begin
        lvt_d = lvt_q;
        if (init_active) begin
            lvt_d[count_q[ADDR_W-1:0]] = 1'b0;
        end else begin
            if (wr_en0) begin
                lvt_d[write_addr0] = 1'b0;
            end
            if (wr_en1) begin
                lvt_d[write_addr1] = 1'b1;
            end
        end
    end

    // Reads sampled during INIT may hit unswept words, so they are masked.
    always_comb begin
        valid_d = run_active;
        for (int r = 0; r < NUM_READ; r++) begin
            lvt_sel_d[r] = lvt_q[`LVT_SLICE(read_addr, r, ADDR_W)];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= LVT_INIT;
            count_q   <= '0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            lvt_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            lvt_sel_q <= lvt_sel_d;
        end
    end

    always_ff @(posedge clock) begin
        lvt_q <= lvt_d;
    end

`ifdef LVT_MEM_BYPASS_EN
    logic [NUM_READ-1:0] byp_hit_q, byp_hit_d;
    logic [WIDTH-1:0]    byp_data_q [NUM_READ];
    logic [WIDTH-1:0]    byp_data_d [NUM_READ];

    always_comb begin
        for (int r = 0; r < NUM_READ; r++) begin
            byp_hit_d[r]  = 1'b0;
            byp_data_d[r] = '0;
            if (wr_en1 && (write_addr1 == `LVT_SLICE(read_addr, r, ADDR_W))) begin
                byp_hit_d[r]  = 1'b1;
                byp_data_d[r] = write_data1;
            end else if (wr_en0 && (write_addr0 == `LVT_SLICE(read_addr, r, ADDR_W))) begin
                byp_hit_d[r]  = 1'b1;
                byp_data_d[r] = write_data0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            byp_hit_q <= '0;
        end else begin
            byp_hit_q <= byp_hit_d;
        end
        byp_data_q <= byp_data_d;
    end
`endif

    always_comb begin
        logic [WIDTH-1:0] word;
        read_data = '0;
        for (int r = 0; r < NUM_READ; r++) begin
            word = lvt_sel_q[r] ? bank1_rdata[r] : bank0_rdata[r];
`ifdef LVT_MEM_BYPASS_EN
            if (byp_hit_q[r]) begin
                word = byp_data_q[r];
            end
`endif
            if (valid_q) begin
                `LVT_SLICE(read_data, r, WIDTH) = word;
            end
        end
    end

    assign ready = ready_q;

    for (genvar r = 0; r < NUM_READ; r++) begin : g_read
        mem_bank_1w1r #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .ADDR_W(ADDR_W)
        ) u_bank0 (
            .clock(clock),
            .we   (bank0_we),
            .waddr(bank0_waddr),
            .wdata(bank0_wdata),
            .raddr(`LVT_SLICE(read_addr, r, ADDR_W)),
            .rdata(bank0_rdata[r])
        );

        mem_bank_1w1r #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .ADDR_W(ADDR_W)
        ) u_bank1 (
            .clock(clock),
            .we   (wr_en1),
            .waddr(write_addr1),
            .wdata(write_data1),
            .raddr(`LVT_SLICE(read_addr, r, ADDR_W)),
            .rdata(bank1_rdata[r])
        );
    end

endmodule
